gba_keypad_ctrl: RTL and testbench

- Parametrised keypad controller for the GBA MMIO space.
- Synchronises and debounces up to 16 raw key inputs.
- Exposes KEYINPUT/KEYCNT as one 32-bit register at BASE_ADR.
- Raises a one-cycle interrupt pulse on the rising edge of the KEYCNT match condition (OR/AND mode), plus a level wake output for the STOP-mode logic; sits beside the other peripherals on the gb_bus.

---
 rtl/gba_keypad_pkg.sv | 38 +++
 rtl/gba_keypad_ctrl_if.sv | 13 +
 rtl/gba_keypad_ctrl_key_debounce.sv | 56 +++++
 rtl/gba_keypad_ctrl.sv | 111 +++++++++++
 tb/tb_gba_keypad_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gba_keypad_pkg.sv
// Shared constants for the GBA keypad controller: KEYCNT bit positions,
// key indices in GBA order and the byte lanes of the {KEYCNT,KEYINPUT} word.
package gba_keypad_pkg;

  localparam int KEYCNT_IRQ_EN = 14;
  localparam int KEYCNT_AND    = 15;

  localparam int KEY_A      = 0;
  localparam int KEY_B      = 1;
  localparam int KEY_SELECT = 2;
  localparam int KEY_START  = 3;
  localparam int KEY_RIGHT  = 4;
  localparam int KEY_LEFT   = 5;
  localparam int KEY_UP     = 6;
  localparam int KEY_DOWN   = 7;
  localparam int KEY_R      = 8;
  localparam int KEY_L      = 9;

  // Count of standard GBA keys in KEYINPUT (A through L).
  localparam int KEYINPUT_STD_KEYS = 10;

  localparam int KEYINPUT_LANE_LO = 0;
  localparam int KEYINPUT_LANE_HI = 1;
  localparam int KEYCNT_LANE_LO   = 2;
  localparam int KEYCNT_LANE_HI   = 3;

  // Merge the upper half-word lanes of a bus write into the current KEYCNT.
  function automatic logic [15:0] keycnt_merge(input logic [15:0] cur,
                                               input logic [15:0] wdata,
                                               input logic [1:0]  lane_en);
    logic [15:0] res;
    res = cur;
    if (lane_en[0]) res[7:0]  = wdata[7:0];
    if (lane_en[1]) res[15:8] = wdata[15:8];
    return res;
  endfunction

endpackage

// File: rtl/gba_keypad_ctrl_if.sv
// Single-cycle gb_bus access port shared by the MMIO peripherals.
interface gba_keypad_ctrl_if;
  logic        ena;
  logic        rnw;
  logic [27:0] adr;
  logic [3:0]  be;
  logic [31:0] din;
  logic [31:0] dout;
  logic        dout_en;

  modport master (output ena, rnw, adr, be, din, input dout, dout_en);
  modport slave  (input ena, rnw, adr, be, din, output dout, dout_en);
endinterface

// File: rtl/gba_keypad_ctrl_key_debounce.sv
// One key: synchroniser chain followed by a persistence counter that only
// accepts a new level after it has been seen for DEBOUNCE_CNT cycles.
module key_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_W   = 16,
  parameter int DEBOUNCE_CNT = 2000
) (
  input  logic mclk,
  input  logic rst_n,
  input  logic key_raw,
  output logic stable
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("key_debounce: SYNC_STAGES must be at least 2");
  end
  if (longint'(DEBOUNCE_CNT) > (64'd1 << DEBOUNCE_W)) begin : g_bad_cnt
    $error("key_debounce: DEBOUNCE_CNT does not fit in DEBOUNCE_W bits");
  end

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   s;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) sync_chain <= '0;
    else        sync_chain <= {sync_chain[SYNC_STAGES-2:0], key_raw};
  end

  assign s = sync_chain[SYNC_STAGES-1];

  if (DEBOUNCE_CNT <= 1) begin : g_bypass
    always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) stable <= 1'b0;
      else        stable <= s;
    end
  end else begin : g_count
    localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CNT - 1);
    logic [DEBOUNCE_W-1:0] cnt;

    // Any return to the accepted level restarts the persistence window.
    always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gba_keypad_ctrl.sv
// GBA keypad controller: debounced keys exposed as {KEYCNT,KEYINPUT} at
// BASE_ADR, with a one-cycle irq on the rising edge of the KEYCNT match.
module gba_keypad_ctrl
  import gba_keypad_pkg::*;
#(
  parameter int          NUM_KEYS     = 10,
  parameter int          SYNC_STAGES  = 2,
  parameter int          DEBOUNCE_W   = 16,
  parameter int          DEBOUNCE_CNT = 2000,
  parameter logic [27:0] BASE_ADR     = 28'h130
) (
  input  logic                mclk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  gba_keypad_ctrl_if.slave    gb_bus,
  output logic                irq,
  output logic                wake,
  output logic [NUM_KEYS-1:0] keys_pressed
);

  if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_keys
    $error("gba_keypad_ctrl: NUM_KEYS must be in 1..16");
  end

  localparam logic [16:0] KEY_BITS     = (17'd1 << NUM_KEYS) - 17'd1;
  localparam logic [15:0] KEYCNT_WMASK = KEY_BITS[15:0]
                                       | (16'd1 << KEYCNT_IRQ_EN)
                                       | (16'd1 << KEYCNT_AND);

  genvar gi;

  for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_W   (DEBOUNCE_W),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
      .mclk    (mclk),
      .rst_n   (rst_n),
      .key_raw (key_raw[gi]),
      .stable  (keys_pressed[gi])
    );
  end

  logic [15:0] keyinput;

  // KEYINPUT is active-low; missing standard keys look released.
  for (gi = 0; gi < 16; gi++) begin : g_keyinput
    if (gi < NUM_KEYS) begin : g_impl
      assign keyinput[gi] = ~keys_pressed[gi];
    end else if (gi < KEYINPUT_STD_KEYS) begin : g_std
      assign keyinput[gi] = 1'b1;
    end else begin : g_none
      assign keyinput[gi] = 1'b0;
    end
  end

  logic [15:0] keycnt;
  logic        addr_hit;
  logic        wr_hit;
  logic        rd_hit;
  logic [15:0] keycnt_new;

  assign addr_hit   = (gb_bus.adr == BASE_ADR);
  assign wr_hit     = gb_bus.ena & ~gb_bus.rnw & addr_hit;
  assign rd_hit     = gb_bus.ena &  gb_bus.rnw & addr_hit;
  assign keycnt_new = keycnt_merge(keycnt, gb_bus.din[31:16],
                                   {gb_bus.be[KEYCNT_LANE_HI], gb_bus.be[KEYCNT_LANE_LO]})
                      & KEYCNT_WMASK;

  logic unused_bus;
  assign unused_bus = ^{gb_bus.din[15:0], gb_bus.be[KEYINPUT_LANE_HI], gb_bus.be[KEYINPUT_LANE_LO]};

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n)      keycnt <= '0;
    else if (wr_hit) keycnt <= keycnt_new;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      gb_bus.dout_en <= 1'b0;
      gb_bus.dout    <= '0;
    end else begin
      gb_bus.dout_en <= rd_hit;
      gb_bus.dout    <= rd_hit ? {keycnt, keyinput} : 32'd0;
    end
  end

  logic [NUM_KEYS-1:0] mask;
  logic [NUM_KEYS-1:0] hits;
  logic                cond;
  logic                cond_q;

  assign mask = keycnt[NUM_KEYS-1:0];
  assign hits = keys_pressed & mask;
  assign cond = keycnt[KEYCNT_IRQ_EN] &
                (keycnt[KEYCNT_AND] ? ((mask != '0) && (hits == mask)) : (|hits));

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q <= 1'b0;
      irq    <= 1'b0;
    end else begin
      cond_q <= cond;
      irq    <= cond & ~cond_q;
    end
  end

  assign wake = cond_q;

endmodule

// File: tb/tb_gba_keypad_ctrl.sv
// Self-checking bench for gba_keypad_ctrl: bus reads are scored against a
// queue of expected words built from a small register/key model.
module tb_gba_keypad_ctrl;

  localparam int          NK   = 10;
  localparam int          SS   = 2;
  localparam int          DC   = 4;
  localparam int          LAT  = SS + DC;
  localparam logic [27:0] BASE = 28'h130;

  logic          mclk;
  logic          rst_n;
  logic [NK-1:0] key_raw;
  logic          irq;
  logic          wake;
  logic [NK-1:0] keys_pressed;

  gba_keypad_ctrl_if bus ();

  gba_keypad_ctrl #(
    .NUM_KEYS     (NK),
    .SYNC_STAGES  (SS),
    .DEBOUNCE_W   (8),
    .DEBOUNCE_CNT (DC),
    .BASE_ADR     (BASE)
  ) dut (
    .mclk         (mclk),
    .rst_n        (rst_n),
    .key_raw      (key_raw),
    .gb_bus       (bus.slave),
    .irq          (irq),
    .wake         (wake),
    .keys_pressed (keys_pressed)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int total = 0;
  int bad   = 0;
  int irq_count = 0;

  logic [15:0]   kc_m;
  logic [NK-1:0] pressed_m;
  logic [31:0]   sb [$];

  always @(negedge mclk) if (irq === 1'b1) irq_count++;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  function automatic logic [31:0] exp_word();
    logic [15:0] ki;
    ki = 16'h03FF;
    ki[NK-1:0] = ~pressed_m;
    return {kc_m, ki};
  endfunction

  task automatic bus_write(input logic [3:0] be, input logic [31:0] data);
    bus.ena = 1'b1; bus.rnw = 1'b0; bus.adr = BASE; bus.be = be; bus.din = data;
    if (be[2]) kc_m[7:0]  = data[23:16];
    if (be[3]) kc_m[15:8] = data[31:24];
    kc_m = kc_m & 16'hC3FF;
    tick();
    bus.ena = 1'b0;
  endtask

  task automatic bus_read(input string name);
    logic [31:0] exp;
    sb.push_back(exp_word());
    bus.ena = 1'b1; bus.rnw = 1'b1; bus.adr = BASE; bus.be = 4'hF;
    tick();
    bus.ena = 1'b0;
    total++;
    if (bus.dout_en !== 1'b1) begin
      bad++;
      $display("FAIL %s_dout_en: got %b want 1", name, bus.dout_en);
      void'(sb.pop_front());
    end else begin
      exp = sb.pop_front();
      total++;
      if (bus.dout !== exp) begin
        bad++;
        $display("FAIL %s_data: got %h want %h", name, bus.dout, exp);
      end else
        $display("read %s: %h", name, bus.dout);
    end
    tick();
    total++;
    if (bus.dout_en !== 1'b0 || bus.dout !== 32'd0) begin
      bad++;
      $display("FAIL %s_idle: got en=%b dout=%h want en=0 dout=0", name, bus.dout_en, bus.dout);
    end
  endtask

  task automatic set_key(input int k, input logic v);
    key_raw[k] = v;
    tick(LAT);
    pressed_m[k] = v;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_raw = '0; bus.ena = 1'b0; bus.rnw = 1'b1;
    bus.adr = '0; bus.be = '0; bus.din = '0;
    kc_m = '0; pressed_m = '0;
    tick(3);
    rst_n = 1'b1;
    tick();
    total++;
    if ({irq, wake, keys_pressed, bus.dout_en, bus.dout} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got irq=%b wake=%b keys=%h en=%b dout=%h want all 0",
               irq, wake, keys_pressed, bus.dout_en, bus.dout);
    end
    bus_read("reset");
  endtask

  task automatic test_debounce();
    logic seen;
    seen = 1'b0;
    key_raw[0] = 1'b1;
    tick(3);
    key_raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (keys_pressed[0] === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL glitch: got accepted want ignored");
    end
    key_raw[0] = 1'b1;
    tick(LAT - 1);
    total++;
    if (keys_pressed[0] !== 1'b0) begin
      bad++;
      $display("FAIL debounce_early: got %b want 0", keys_pressed[0]);
    end
    tick();
    total++;
    if (keys_pressed[0] !== 1'b1) begin
      bad++;
      $display("FAIL debounce_latency: got %b want 1", keys_pressed[0]);
    end
    pressed_m[0] = 1'b1;
    bus_read("key_a_held");
    set_key(0, 1'b0);
    chk("debounce_release", 32'(keys_pressed), 32'(pressed_m));
  endtask

  task automatic test_reg_lanes();
    int base;
    base = irq_count;
    bus_write(4'b0011, 32'hFFFF_FFFF);
    bus_read("lane_keyinput_ignored");
    bus_write(4'b1100, 32'hFFFF_0000);
    bus_read("lane_full");
    bus_write(4'b0100, 32'h00AA_0000);
    bus_read("lane_lo");
    bus_write(4'b1000, 32'h0000_0000);
    bus_read("lane_hi");
    bus_write(4'b1100, 32'h0000_0000);
    chk("lane_no_irq", 32'(irq_count - base), 32'd0);
  endtask

  task automatic test_or_mode();
    int base;
    base = irq_count;
    bus_write(4'b1100, 32'h4003_0000);
    set_key(1, 1'b1);
    chk("or_irq_not_yet", 32'(irq), 32'd0);
    tick();
    chk("or_irq_pulse", 32'(irq), 32'd1);
    chk("or_wake", 32'(wake), 32'd1);
    tick();
    chk("or_irq_one_cycle", 32'(irq), 32'd0);
    tick(100);
    chk("or_hold_single", 32'(irq_count - base), 32'd1);
    bus_read("or_b_held");
    set_key(1, 1'b0);
    tick(2);
    chk("or_release_wake", 32'(wake), 32'd0);
    set_key(0, 1'b1);
    tick(2);
    chk("or_rearm", 32'(irq_count - base), 32'd2);
    set_key(0, 1'b0);
    tick(2);
  endtask

  task automatic test_and_mode();
    int base;
    base = irq_count;
    bus_write(4'b1100, 32'hC300_0000);
    set_key(8, 1'b1);
    tick(3);
    chk("and_partial_irq", 32'(irq_count - base), 32'd0);
    chk("and_partial_wake", 32'(wake), 32'd0);
    set_key(9, 1'b1);
    tick(2);
    chk("and_full_irq", 32'(irq_count - base), 32'd1);
    chk("and_full_wake", 32'(wake), 32'd1);
    set_key(8, 1'b0);
    tick(2);
    chk("and_release_wake", 32'(wake), 32'd0);
    chk("and_release_irq", 32'(irq_count - base), 32'd1);
    bus_read("and_l_held");
    set_key(9, 1'b0);
    tick(2);
  endtask

  task automatic test_write_cond();
    int base;
    bus_write(4'b1100, 32'h0000_0000);
    set_key(3, 1'b1);
    tick(2);
    base = irq_count;
    bus_write(4'b1100, 32'h4008_0000);
    chk("wr_irq_not_yet", 32'(irq), 32'd0);
    tick();
    chk("wr_irq_pulse", 32'(irq), 32'd1);
    tick();
    chk("wr_irq_one_cycle", 32'(irq), 32'd0);
    chk("wr_wake", 32'(wake), 32'd1);
    bus_write(4'b1100, 32'h0008_0000);
    tick();
    chk("wr_clear_wake", 32'(wake), 32'd0);
    tick(3);
    chk("wr_clear_no_pulse", 32'(irq_count - base), 32'd1);
    bus_read("start_held");
    set_key(3, 1'b0);
    tick(2);
  endtask

  task automatic test_reset_mid();
    int base;
    bus_write(4'b1100, 32'h4001_0000);
    key_raw[0] = 1'b1;
    key_raw[1] = 1'b1;
    tick(LAT - 2);
    key_raw[2] = 1'b1;
    tick(2);
    base = irq_count;
    rst_n = 1'b0;
    #1;
    total++;
    if ({irq, wake, keys_pressed, bus.dout_en, bus.dout} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got irq=%b wake=%b keys=%h en=%b dout=%h want all 0",
               irq, wake, keys_pressed, bus.dout_en, bus.dout);
    end
    key_raw = '0;
    tick(2);
    rst_n = 1'b1;
    kc_m = '0;
    pressed_m = '0;
    bus_read("after_reset");
    tick(10);
    chk("reset_no_irq", 32'(irq_count - base), 32'd0);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_reg_lanes();
    test_or_mode();
    test_and_mode();
    test_write_cond();
    test_reset_mid();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
